// File: rtl/load_store_unit_pkg.sv
// Shared constants for the data-memory stage: memory-op codes and LSU state codes.
// Imported by the lane aligner and the load/store unit.
package load_store_unit_pkg;

  localparam logic [2:0] MEM_OP_LB  = 3'd0;
  localparam logic [2:0] MEM_OP_LBU = 3'd1;
  localparam logic [2:0] MEM_OP_LH  = 3'd2;
  localparam logic [2:0] MEM_OP_LHU = 3'd3;
  localparam logic [2:0] MEM_OP_LW  = 3'd4;
  localparam logic [2:0] MEM_OP_SB  = 3'd5;
  localparam logic [2:0] MEM_OP_SH  = 3'd6;
  localparam logic [2:0] MEM_OP_SW  = 3'd7;

  localparam logic [1:0] LSU_ST_IDLE = 2'd0;
  localparam logic [1:0] LSU_ST_BUSY = 2'd1;
  localparam logic [1:0] LSU_ST_RESP = 2'd2;

  function automatic logic mem_op_is_store(input logic [2:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-bus signals of the load/store unit.
// slave: seen by the LSU; master: seen by the core/bus side.
interface load_store_unit_if;
  logic        op_valid;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport slave (
    input  op_valid, mem_op, addr, wdata, bus_ack, bus_rdata,
    output stall, done, rdata, addr_err, bus_req, bus_we, bus_addr, bus_be,
           bus_wdata, bus_err
  );

  modport master (
    output op_valid, mem_op, addr, wdata, bus_ack, bus_rdata,
    input  stall, done, rdata, addr_err, bus_req, bus_we, bus_addr, bus_be,
           bus_wdata, bus_err
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: byte-lane steering for stores and extraction/extension for loads.
// Purely combinational; also flags misaligned or unknown memory ops.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_mem_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_bus_rdata,
  output logic        o_we,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_bus_rdata[7:0];
      2'd1:    w_byte = i_bus_rdata[15:8];
      2'd2:    w_byte = i_bus_rdata[23:16];
      default: w_byte = i_bus_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
  end

  always_comb begin
    o_we        = 1'b0;
    o_be        = 4'b1111;
    o_wdata     = 32'h0;
    o_load_data = 32'h0;
    o_misalign  = 1'b0;
    case (i_mem_op)
      MEM_OP_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
      MEM_OP_LBU: o_load_data = {24'h0, w_byte};
      MEM_OP_LH: begin
        o_misalign  = i_addr_lo[0];
        o_load_data = {{16{w_half[15]}}, w_half};
      end
      MEM_OP_LHU: begin
        o_misalign  = i_addr_lo[0];
        o_load_data = {16'h0, w_half};
      end
      MEM_OP_LW: begin
        o_misalign  = |i_addr_lo;
        o_load_data = i_bus_rdata;
      end
      MEM_OP_SB: begin
        o_we    = 1'b1;
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      MEM_OP_SH: begin
        o_we       = 1'b1;
        o_misalign = i_addr_lo[0];
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
      end
      MEM_OP_SW: begin
        o_we       = 1'b1;
        o_misalign = |i_addr_lo;
        o_wdata    = i_wdata;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one req/ack bus transaction per memory op, stalling the core until done.
// Optional bus timeout abort built only with LSU_BUS_TIMEOUT_EN defined.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave lsu
);

  logic [1:0]  r_state;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic        r_done;
  logic [31:0] r_rdata;
  logic        r_addr_err;
  logic [2:0]  r_mem_op;
  logic [1:0]  r_addr_lo;

  logic [2:0]  w_op;
  logic [1:0]  w_addr_lo;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic        w_misalign;

  // Issue uses the live request; load extraction uses the op captured at issue.
  assign w_op      = (r_state == LSU_ST_IDLE) ? lsu.mem_op    : r_mem_op;
  assign w_addr_lo = (r_state == LSU_ST_IDLE) ? lsu.addr[1:0] : r_addr_lo;

  lsu_lane_align u_align (
    .i_mem_op    (w_op),
    .i_addr_lo   (w_addr_lo),
    .i_wdata     (lsu.wdata),
    .i_bus_rdata (lsu.bus_rdata),
    .o_we        (w_we),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data),
    .o_misalign  (w_misalign)
  );

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
  assign lsu.bus_err = r_bus_err;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign lsu.bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LSU_ST_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_be    <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_done      <= 1'b0;
      r_rdata     <= 32'h0;
      r_addr_err  <= 1'b0;
      r_mem_op    <= 3'h0;
      r_addr_lo   <= 2'h0;
`ifdef LSU_BUS_TIMEOUT_EN
      r_cnt       <= '0;
      r_bus_err   <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_addr_err <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
      r_bus_err  <= 1'b0;
`endif
      case (r_state)
        LSU_ST_IDLE: begin
          if (lsu.op_valid) begin
            r_mem_op  <= lsu.mem_op;
            r_addr_lo <= lsu.addr[1:0];
            if (w_misalign) begin
              r_state    <= LSU_ST_RESP;
              r_done     <= 1'b1;
              r_addr_err <= 1'b1;
              r_rdata    <= 32'h0;
            end else begin
              r_state     <= LSU_ST_BUSY;
              r_bus_req   <= 1'b1;
              r_bus_we    <= w_we;
              r_bus_addr  <= {lsu.addr[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
`ifdef LSU_BUS_TIMEOUT_EN
              r_cnt       <= '0;
`endif
            end
          end
        end
        LSU_ST_BUSY: begin
          if (lsu.bus_ack) begin
            r_bus_req <= 1'b0;
            r_rdata   <= w_load_data;
            r_done    <= 1'b1;
            r_state   <= LSU_ST_RESP;
          end
`ifdef LSU_BUS_TIMEOUT_EN
          else if (r_cnt == CNT_LAST) begin
            r_cnt     <= r_cnt + 1'b1;
            r_bus_req <= 1'b0;
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= LSU_ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        LSU_ST_RESP: r_state <= LSU_ST_IDLE;
        default:     r_state <= LSU_ST_IDLE;
      endcase
    end
  end

  assign lsu.stall     = ((r_state == LSU_ST_IDLE) && lsu.op_valid) || (r_state == LSU_ST_BUSY);
  assign lsu.done      = r_done;
  assign lsu.rdata     = r_rdata;
  assign lsu.addr_err  = r_addr_err;
  assign lsu.bus_req   = r_bus_req;
  assign lsu.bus_we    = r_bus_we;
  assign lsu.bus_addr  = r_bus_addr;
  assign lsu.bus_be    = r_bus_be;
  assign lsu.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus random ops against a reference model.
// Timeout cases are compiled in when LSU_BUS_TIMEOUT_EN is defined.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned TMO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        addr_err;
    logic        bus_err;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } bus_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  load_store_unit_if lsu();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (lsu)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  resp_t exp_q[$];
  bus_t  bus_q[$];

  int          rsp_delay = 1;
  logic        rsp_noack = 1'b0;
  logic [31:0] rsp_rdata = 32'h0;
  int          pulse_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the memory stage should do for one op, by plain arithmetic.
  function automatic logic model_mis(input logic [2:0] op, input logic [31:0] a);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1'b0;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return (a % 2) != 0;
      MEM_OP_LW, MEM_OP_SW:             return (a % 4) != 0;
      default:                          return 1'b1;
    endcase
  endfunction

  function automatic logic model_store(input logic [2:0] op);
    return op == MEM_OP_SB || op == MEM_OP_SH || op == MEM_OP_SW;
  endfunction

  function automatic resp_t model_resp(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] rd, input logic tmo);
    resp_t r;
    logic [31:0] b, h;
    r.rdata = 32'h0; r.addr_err = 1'b0; r.bus_err = 1'b0;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    if (model_mis(op, a))  r.addr_err = 1'b1;
    else if (tmo)          r.bus_err = 1'b1;
    else if (!model_store(op)) begin
      case (op)
        MEM_OP_LB:  r.rdata = (b < 128) ? b : b + 32'hFFFF_FF00;
        MEM_OP_LBU: r.rdata = b;
        MEM_OP_LH:  r.rdata = (h < 32768) ? h : h + 32'hFFFF_0000;
        MEM_OP_LHU: r.rdata = h;
        default:    r.rdata = rd;
      endcase
    end
    return r;
  endfunction

  function automatic bus_t model_bus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    bus_t t;
    t.we = model_store(op);
    t.addr = (a / 4) * 4;
    t.chk_wdata = t.we;
    t.be = 4'hF;
    t.wdata = wd;
    if (op == MEM_OP_SB) begin
      t.be = 4'(1 << (a % 4));
      t.wdata = (wd & 32'hFF) * 32'h0101_0101;
    end else if (op == MEM_OP_SH) begin
      t.be = 4'(3 << (a % 4));
      t.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    end
    return t;
  endfunction

  // Bus responder: acks after rsp_delay BUSY cycles, or on request a stray one-cycle ack.
  initial begin
    int cnt;
    int pulse_done;
    cnt = 0;
    pulse_done = 0;
    lsu.bus_ack = 1'b0;
    lsu.bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (lsu.bus_ack) begin
        lsu.bus_ack = 1'b0;
        cnt = 0;
      end else if (pulse_req != pulse_done) begin
        pulse_done = pulse_req;
        lsu.bus_ack = 1'b1;
        lsu.bus_rdata = 32'hFFFF_FFFF;
      end else if (lsu.bus_req) begin
        cnt++;
        if (!rsp_noack && cnt == rsp_delay) begin
          lsu.bus_ack = 1'b1;
          lsu.bus_rdata = rsp_rdata;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Bus monitor: new request checked against the expected transaction, then held stable.
  initial begin
    logic prev;
    bus_t e;
    prev = 1'b0;
    e = '{we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0, chk_wdata: 1'b0};
    forever begin
      @(negedge clk);
      if (lsu.bus_req && !prev) begin
        if (bus_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_bus_req: got bus_req=1 expected none at %0t", $time);
        end else begin
          e = bus_q.pop_front();
          check("bus_we", 32'(lsu.bus_we), 32'(e.we));
          check("bus_addr", lsu.bus_addr, e.addr);
          check("bus_be", 32'(lsu.bus_be), 32'(e.be));
          if (e.chk_wdata) check("bus_wdata", lsu.bus_wdata, e.wdata);
        end
      end else if (lsu.bus_req) begin
        check("bus_addr_hold", lsu.bus_addr, e.addr);
        check("bus_be_hold", 32'(lsu.bus_be), 32'(e.be));
      end
      prev = lsu.bus_req;
    end
  end

  // Response monitor: every done pulse is matched against the next expected result.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (lsu.done) begin
        check("stall_in_done", 32'(lsu.stall), 32'd0);
        check("bus_req_in_done", 32'(lsu.bus_req), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
        end else begin
          r = exp_q.pop_front();
          check("rdata", lsu.rdata, r.rdata);
          check("addr_err", 32'(lsu.addr_err), 32'(r.addr_err));
          check("bus_err", 32'(lsu.bus_err), 32'(r.bus_err));
        end
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int delay, input logic noack);
    logic mis, tmo;
    int n, lat;
    mis = model_mis(op, a);
`ifdef LSU_BUS_TIMEOUT_EN
    tmo = !mis && (noack || delay > int'(TMO));
`else
    tmo = 1'b0;
`endif
    lat = mis ? 1 : (tmo ? int'(TMO) + 1 : delay + 1);
    @(negedge clk);
    exp_q.push_back(model_resp(op, a, rd, tmo));
    if (!mis) bus_q.push_back(model_bus(op, a, wd));
    rsp_delay = delay; rsp_noack = noack; rsp_rdata = rd;
    lsu.op_valid = 1'b1; lsu.mem_op = op; lsu.addr = a; lsu.wdata = wd;
    #1;
    check("stall_on_issue", 32'(lsu.stall), 32'd1);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (lsu.done) break;
      check("stall_while_busy", 32'(lsu.stall), 32'd1);
    end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL done_wait: got no done in 200 cycles expected latency %0d", lat);
    end else begin
      check("latency", 32'(n), 32'(lat));
    end
    lsu.op_valid = 1'b0;
  endtask

  initial begin
    int n;
    lsu.op_valid = 1'b0;
    lsu.mem_op = MEM_OP_LW;
    lsu.addr = 32'h0;
    lsu.wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", 32'(lsu.bus_req), 32'd0);
    check("rst_done", 32'(lsu.done), 32'd0);
    check("rst_rdata", lsu.rdata, 32'd0);
    check("rst_bus_addr", lsu.bus_addr, 32'd0);
    check("rst_bus_be", 32'(lsu.bus_be), 32'd0);
    check("rst_stall", 32'(lsu.stall), 32'd0);
    rst = 1'b0;

    do_op(MEM_OP_LW,  32'h100, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    do_op(MEM_OP_LB,  32'h103, 32'h0, 32'h8011_2233, 1, 1'b0);
    do_op(MEM_OP_LBU, 32'h103, 32'h0, 32'h8011_2233, 2, 1'b0);
    do_op(MEM_OP_LHU, 32'h102, 32'h0, 32'h8011_2233, 1, 1'b0);
    do_op(MEM_OP_LH,  32'h102, 32'h0, 32'h8011_2233, 1, 1'b0);
    do_op(MEM_OP_SH,  32'h102, 32'hAAAA_1234, 32'h5555_5555, 2, 1'b0);
    do_op(MEM_OP_SB,  32'h101, 32'h0000_005A, 32'h0, 1, 1'b0);
    do_op(MEM_OP_SW,  32'h104, 32'hCAFE_F00D, 32'h0, 1, 1'b0);
    do_op(MEM_OP_LW,  32'h102, 32'h0, 32'h1234_5678, 1, 1'b0);
    do_op(MEM_OP_LH,  32'h101, 32'h0, 32'h1234_5678, 1, 1'b0);

    // Reset while BUSY, then a stray ack: nothing may complete.
    @(negedge clk);
    bus_q.push_back(model_bus(MEM_OP_LW, 32'h200, 32'h0));
    rsp_noack = 1'b1;
    lsu.op_valid = 1'b1; lsu.mem_op = MEM_OP_LW; lsu.addr = 32'h200;
    n = 0;
    while (n < 20 && !lsu.bus_req) begin @(negedge clk); n++; end
    check("rst_test_saw_req", 32'(lsu.bus_req), 32'd1);
    lsu.op_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_bus_req", 32'(lsu.bus_req), 32'd0);
    check("rst_mid_done", 32'(lsu.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_req++;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_done", 32'(lsu.done), 32'd0);
      check("post_rst_bus_req", 32'(lsu.bus_req), 32'd0);
      check("post_rst_stall", 32'(lsu.stall), 32'd0);
    end
    rsp_noack = 1'b0;
    do_op(MEM_OP_LW, 32'h204, 32'h0, 32'h0BAD_CAFE, 2, 1'b0);

`ifdef LSU_BUS_TIMEOUT_EN
    do_op(MEM_OP_LW, 32'h300, 32'h0, 32'h1111_2222, 1, 1'b1);
    do_op(MEM_OP_LW, 32'h304, 32'h0, 32'h3333_4444, int'(TMO), 1'b0);
    do_op(MEM_OP_SW, 32'h308, 32'h5555_6666, 32'h0, int'(TMO) + 1, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            int'($urandom_range(1, 6)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected end of test");
    $fatal(1, "global timeout");
  end

endmodule
